quadrature_step_decoder: RTL

//   Turns raw two-phase quadrature inputs (a_in, b_in) into single-cycle step

---
 rtl/quadrature_step_decoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/quadrature_step_decoder.sv
// Quadrature front end: two-FF synchroniser, per-channel level filter and Gray-code
// step decode producing one-cycle step strobes plus a direction and sticky error flag.
//
// state   | meaning
// --------+------------------------------------------------------------------
// ST_INIT | waiting for the synchroniser to prime, then snapshots pins into f/p
// ST_RUN  | filtering and decoding; left only through reset
module quadrature_step_decoder #(
  parameter int FILTER_LEN = 3,
  parameter int CNT_W      = 4,
  parameter int X4_MODE    = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_in,
  input  logic b_in,
  input  logic en,
  input  logic err_clr,
  output logic step_en,
  output logic step_up,
  output logic err
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] FLT_TC   = CNT_W'(FILTER_LEN - 1);
  localparam logic [1:0]       INIT_LEN = 2'd2;

  logic [0:0]            state;
  logic [1:0]            init_tmr;
  logic [1:0]            sync_q1;
  logic [1:0]            sync_q2;
  logic [1:0]            f_q;
  logic [1:0]            p_q;
  logic [1:0][CNT_W-1:0] flt_cnt;
  logic [1:0]            f_nxt;
  logic [1:0][CNT_W-1:0] cnt_nxt;
  logic                  run;
  logic                  legal;
  logic                  illegal;
  logic                  dir_up;
  logic                  do_step;
  logic                  set_err;

  // Bit 1 carries phase A, bit 0 phase B, matching the AB notation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1 <= 2'b00;
      sync_q2 <= 2'b00;
    end else begin
      sync_q1 <= {a_in, b_in};
      sync_q2 <= sync_q1;
    end
  end

  // A channel's filtered level flips only after the opposite level has been seen
  // for FILTER_LEN consecutive cycles; any return to f restarts the count.
  always_comb begin
    f_nxt   = f_q;
    cnt_nxt = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q2[i] != f_q[i]) begin
        if (flt_cnt[i] == FLT_TC) begin
          f_nxt[i] = sync_q2[i];
        end else begin
          cnt_nxt[i] = flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_tmr <= INIT_LEN;
      f_q      <= 2'b00;
      p_q      <= 2'b00;
      flt_cnt  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_tmr == 2'd0) begin
            f_q   <= sync_q2;
            p_q   <= sync_q2;
            state <= ST_RUN;
          end else begin
            init_tmr <= init_tmr - 2'd1;
          end
        end
        default: begin
          p_q     <= f_q;
          f_q     <= f_nxt;
          flt_cnt <= cnt_nxt;
        end
      endcase
    end
  end

  // One bit changed is a legal step; in the up direction the old A differs from the new B.
  assign run     = (state == ST_RUN);
  assign legal   = ^(p_q ^ f_q);
  assign illegal = &(p_q ^ f_q);
  assign dir_up  = p_q[1] ^ f_q[0];
  assign do_step = run && en && legal && ((X4_MODE != 0) || (f_q == 2'b00));
  assign set_err = run && en && illegal;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step_en <= 1'b0;
      step_up <= 1'b1;
      err     <= 1'b0;
    end else begin
      step_en <= do_step;
      if (do_step) begin
        step_up <= dir_up;
      end
      if (set_err) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule
